// File: rtl/level_fb_pkg.sv
// Shared framebuffer constants and writer state encoding for the level image RAM.
package level_fb_pkg;

  localparam int unsigned FB_WIDTH  = 640;
  localparam int unsigned FB_HEIGHT = 480;
  localparam int unsigned FB_ADDR_W = 20;
  localparam int unsigned FB_DATA_W = 9;
  localparam int unsigned FB_DIM_W  = 6;

  // Request coordinate widths (column 0..1023, row 0..511 on the port).
  localparam int unsigned X_W = 10;
  localparam int unsigned Y_W = 9;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLIP  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/level_rect_writer.sv
// Rectangle-fill writer: clips a request to the screen and emits one pixel
// write per blanking cycle into the level image RAM (addr = x + WIDTH*y).
module level_rect_writer
  import level_fb_pkg::*;
#(
  parameter int unsigned WIDTH  = FB_WIDTH,
  parameter int unsigned HEIGHT = FB_HEIGHT,
  parameter int unsigned ADDR_W = FB_ADDR_W,
  parameter int unsigned DATA_W = FB_DATA_W,
  parameter int unsigned DIM_W  = FB_DIM_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [X_W-1:0]    req_x_i,
  input  logic [Y_W-1:0]    req_y_i,
  input  logic [DIM_W-1:0]  req_w_i,
  input  logic [DIM_W-1:0]  req_h_i,
  input  logic [DATA_W-1:0] req_color_i,
  input  logic              blank_i,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [DATA_W-1:0] wr_data_o,
  output logic              busy_o,
  output logic              done_o
);

  // One extra bit so x+w and y+h never wrap before clipping.
  localparam int unsigned XE_W = X_W + 1;
  localparam int unsigned YE_W = Y_W + 1;

  state_e              state_q, state_d;
  logic [X_W-1:0]      x_q, x_d;
  logic [Y_W-1:0]      y_q, y_d;
  logic [DIM_W-1:0]    w_q, w_d, h_q, h_d;
  logic [DATA_W-1:0]   color_q, color_d;
  logic [XE_W-1:0]     x_end_q, x_end_d, col_q, col_d;
  logic [YE_W-1:0]     y_end_q, y_end_d, row_q, row_d;
  logic [ADDR_W-1:0]   row_base_q, row_base_d, addr_q, addr_d;
  logic                req_ready_q, req_ready_d;
  logic                wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                accept;
  logic [XE_W-1:0]     x_sum;
  logic [YE_W-1:0]     y_sum;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state, clipping, address stepping and registered-output values.
  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    w_d         = w_q;
    h_d         = h_q;
    color_d     = color_q;
    x_end_d     = x_end_q;
    y_end_d     = y_end_q;
    col_d       = col_q;
    row_d       = row_q;
    row_base_d  = row_base_q;
    addr_d      = addr_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    done_d      = 1'b0;
    accept      = (state_q == S_IDLE) && req_valid_i && req_ready_q;
    x_sum       = XE_W'(x_q) + XE_W'(w_q);
    y_sum       = YE_W'(y_q) + YE_W'(h_q);

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          x_d     = req_x_i;
          y_d     = req_y_i;
          w_d     = req_w_i;
          h_d     = req_h_i;
          color_d = req_color_i;
          state_d = S_CLIP;
        end
      end
      S_CLIP: begin
        x_end_d    = (x_sum > XE_W'(WIDTH))  ? XE_W'(WIDTH)  : x_sum;
        y_end_d    = (y_sum > YE_W'(HEIGHT)) ? YE_W'(HEIGHT) : y_sum;
        col_d      = XE_W'(x_q);
        row_d      = YE_W'(y_q);
        row_base_d = ADDR_W'(x_q) + ADDR_W'(y_q) * ADDR_W'(WIDTH);
        addr_d     = row_base_d;
        if ((w_q == '0) || (h_q == '0) ||
            (XE_W'(x_q) >= XE_W'(WIDTH)) || (YE_W'(y_q) >= YE_W'(HEIGHT)))
          state_d = S_DONE;
        else
          state_d = S_WRITE;
      end
      S_WRITE: begin
        // Only write during blanking; otherwise every counter holds.
        if (blank_i) begin
          wr_en_d   = 1'b1;
          wr_addr_d = addr_q;
          wr_data_d = color_q;
          if (col_q == x_end_q - XE_W'(1)) begin
            if (row_q == y_end_q - YE_W'(1)) begin
              state_d = S_DONE;
            end else begin
              col_d      = XE_W'(x_q);
              row_d      = row_q + YE_W'(1);
              row_base_d = row_base_q + ADDR_W'(WIDTH);
              addr_d     = row_base_q + ADDR_W'(WIDTH);
            end
          end else begin
            col_d  = col_q + XE_W'(1);
            addr_d = addr_q + ADDR_W'(1);
          end
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d      = (state_d != S_IDLE);
    req_ready_d = (state_q == S_IDLE) && !accept;
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      x_q         <= '0;
      y_q         <= '0;
      w_q         <= '0;
      h_q         <= '0;
      color_q     <= '0;
      x_end_q     <= '0;
      y_end_q     <= '0;
      col_q       <= '0;
      row_q       <= '0;
      row_base_q  <= '0;
      addr_q      <= '0;
      req_ready_q <= 1'b1;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      x_q         <= x_d;
      y_q         <= y_d;
      w_q         <= w_d;
      h_q         <= h_d;
      color_q     <= color_d;
      x_end_q     <= x_end_d;
      y_end_q     <= y_end_d;
      col_q       <= col_d;
      row_q       <= row_d;
      row_base_q  <= row_base_d;
      addr_q      <= addr_d;
      req_ready_q <= req_ready_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign req_ready_o = req_ready_q;
  assign wr_en_o     = wr_en_q;
  assign wr_addr_o   = wr_addr_q;
  assign wr_data_o   = wr_data_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;

endmodule

// File: tb/tb_level_rect_writer.sv
// Bench for level_rect_writer: directed and random rectangles against a
// pixel-list reference model with per-cycle timing expectations.
module tb_level_rect_writer;

  localparam int SCR_W = 640;
  localparam int SCR_H = 480;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [9:0]  req_x;
  logic [8:0]  req_y;
  logic [5:0]  req_w;
  logic [5:0]  req_h;
  logic [8:0]  req_color;
  logic        blank;
  logic        wr_en;
  logic [19:0] wr_addr;
  logic [8:0]  wr_data;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  level_rect_writer dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_x_i     (req_x),
    .req_y_i     (req_y),
    .req_w_i     (req_w),
    .req_h_i     (req_h),
    .req_color_i (req_color),
    .blank_i     (blank),
    .wr_en_o     (wr_en),
    .wr_addr_o   (wr_addr),
    .wr_data_o   (wr_data),
    .busy_o      (busy),
    .done_o      (done)
  );

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int x, input int y, input int w, input int h, input int col);
    req_x     = 10'(x);
    req_y     = 9'(y);
    req_w     = 6'(w);
    req_h     = 6'(h);
    req_color = 9'(col);
  endtask

  // Issue one rectangle and check every cycle until it completes.
  // mode 0: blank always high; mode 1: blank random. stall_first forces
  // blank low on the first write-eligible edges. abort_after >= 0 applies
  // reset once that many pixels were written.
  task automatic run_rect(input int x, input int y, input int w, input int h, input int col,
                          input int mode, input int stall_first, input int abort_after,
                          input bit hold_next, input int nx, input int ny, input int nw,
                          input int nh, input int ncol);
    int q[$];
    int xe, ye, done_e, n_wr, stall_left, exp_addr;
    bit b;
    xe = (x + w > SCR_W) ? SCR_W : x + w;
    ye = (y + h > SCR_H) ? SCR_H : y + h;
    if (w > 0 && h > 0 && x < SCR_W && y < SCR_H)
      for (int yy = y; yy < ye; yy++)
        for (int xx = x; xx < xe; xx++)
          q.push_back(xx + SCR_W * yy);

    check_eq("ready_idle", int'(req_ready), 1);
    drive(x, y, w, h, col);
    req_valid = 1'b1;
    blank     = 1'b1;
    tick();  // accept edge N
    if (hold_next) drive(nx, ny, nw, nh, ncol);
    else           req_valid = 1'b0;
    check_eq("ready_accept", int'(req_ready), 0);
    check_eq("busy_accept", int'(busy), 1);
    check_eq("wr_en_accept", int'(wr_en), 0);
    check_eq("done_accept", int'(done), 0);

    done_e     = (q.size() == 0) ? 2 : -1;
    stall_left = stall_first;
    n_wr       = 0;
    for (int e = 1; e < 6000; e++) begin
      b = (mode == 0) || ($urandom_range(0, 3) != 0);
      if (e >= 2 && stall_left > 0) begin
        b = 1'b0;
        stall_left--;
      end
      blank = b;
      tick();
      if (e >= 2 && b && q.size() > 0) begin
        exp_addr = q.pop_front();
        check_eq("wr_en", int'(wr_en), 1);
        check_eq("wr_addr", int'(wr_addr), exp_addr);
        check_eq("wr_data", int'(wr_data), col);
        n_wr++;
        if (q.size() == 0) done_e = e + 1;
      end else begin
        check_eq("wr_en_idle", int'(wr_en), 0);
      end
      check_eq("done", int'(done), int'(e == done_e));
      check_eq("busy", int'(busy), int'(e < done_e || done_e < 0));
      check_eq("ready_busy", int'(req_ready), 0);

      if (n_wr == abort_after) begin
        reset = 1'b1;
        tick();
        check_eq("rst_wr_en", int'(wr_en), 0);
        check_eq("rst_busy", int'(busy), 0);
        check_eq("rst_done", int'(done), 0);
        check_eq("rst_wr_addr", int'(wr_addr), 0);
        check_eq("rst_wr_data", int'(wr_data), 0);
        check_eq("rst_ready", int'(req_ready), 1);
        reset = 1'b0;
        return;
      end

      if (e == done_e) begin
        tick();
        check_eq("ready_after_done", int'(req_ready), 1);
        check_eq("done_one_cycle", int'(done), 0);
        check_eq("busy_after_done", int'(busy), 0);
        check_eq("wr_en_after_done", int'(wr_en), 0);
        return;
      end
    end
    n_checks++;
    n_fail++;
    $display("FAIL timeout: rect (%0d,%0d) %0dx%0d never completed", x, y, w, h);
  endtask

  initial begin
    int rx, ry;
    reset     = 1'b1;
    req_valid = 1'b0;
    blank     = 1'b1;
    drive(0, 0, 0, 0, 0);
    repeat (3) tick();
    check_eq("reset_ready", int'(req_ready), 1);
    check_eq("reset_wr_en", int'(wr_en), 0);
    check_eq("reset_wr_addr", int'(wr_addr), 0);
    check_eq("reset_wr_data", int'(wr_data), 0);
    check_eq("reset_busy", int'(busy), 0);
    check_eq("reset_done", int'(done), 0);
    reset = 1'b0;

    // Basic 3x2 fill.
    run_rect(10, 20, 3, 2, 5, 0, 0, -1, 1'b0, 0, 0, 0, 0, 0);
    // Bottom-right corner clipping.
    run_rect(638, 479, 4, 4, 17, 0, 0, -1, 1'b0, 0, 0, 0, 0, 0);
    // Empty and off-screen requests.
    run_rect(5, 5, 0, 7, 3, 0, 0, -1, 1'b0, 0, 0, 0, 0, 0);
    run_rect(5, 5, 7, 0, 3, 0, 0, -1, 1'b0, 0, 0, 0, 0, 0);
    run_rect(640, 10, 3, 3, 3, 0, 0, -1, 1'b0, 0, 0, 0, 0, 0);
    run_rect(10, 480, 3, 3, 3, 0, 0, -1, 1'b0, 0, 0, 0, 0, 0);
    // Stalled by active display for three cycles.
    run_rect(0, 0, 2, 1, 1, 0, 3, -1, 1'b0, 0, 0, 0, 0, 0);
    // Reset mid-write, then a request accepted straight away.
    run_rect(100, 100, 3, 2, 44, 0, 0, 3, 1'b0, 0, 0, 0, 0, 0);
    run_rect(1, 1, 2, 2, 9, 0, 0, -1, 1'b0, 0, 0, 0, 0, 0);
    // Second request held valid while busy.
    run_rect(20, 30, 4, 3, 7, 1, 0, -1, 1'b1, 50, 60, 2, 2, 9);
    run_rect(50, 60, 2, 2, 9, 1, 0, -1, 1'b0, 0, 0, 0, 0, 0);

    // Random rectangles, biased toward the right/bottom edges.
    for (int i = 0; i < 30; i++) begin
      rx = (i % 3 == 0) ? int'($urandom_range(600, 700)) : int'($urandom_range(0, 700));
      ry = (i % 4 == 0) ? int'($urandom_range(470, 500)) : int'($urandom_range(0, 500));
      run_rect(rx, ry, int'($urandom_range(0, 63)), int'($urandom_range(0, 8)),
               int'($urandom_range(0, 511)), 1, 0, -1, 1'b0, 0, 0, 0, 0, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
